stall_ctrl: RTL and testbench

- Pipeline interlock controller sitting directly downstream of the ID-stage hazard checker. It consumes the checker's 2-bit stall request (0 none, 1 producer in MEM, 2 producer in EXE) and turns it into a multi-cycle hold of PC/IF-ID plus bubble injection into ID/EXE.
- Also arbitrates against branch redirect flushes from EXE.
- Owns a down-counter, so the request is sampled once per hazard, not re-evaluated each cycle.

---
 rtl/pipeline_pkg.sv | 11 +
 rtl/stall_ctrl.sv | 84 ++++++++
 tb/tb_stall_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared stall encodings, interlock FSM states and default counter width.
//   STALL_NONE/MEM/EXE : hazard checker stall request encodings (value = bubbles)
//   state_t            : interlock controller states
//   CNT_W              : default width of stall request and bubble counter
package pipeline_pkg;
    localparam int CNT_W = 2;
    localparam logic [1:0] STALL_NONE = 2'd0;
    localparam logic [1:0] STALL_MEM  = 2'd1;
    localparam logic [1:0] STALL_EXE  = 2'd2;
    typedef enum logic {STALL_IDLE, STALL_BUSY} state_t;
endpackage

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline interlock; turns a sampled stall request into a multi-cycle
// PC/IF-ID hold with ID/EXE bubbles, preempted by branch redirect flushes.
//   clk, resetn        : clock, synchronous active-low reset
//   is_stall           : bubbles requested by the hazard checker (0 = none)
//   id_valid           : ID stage holds a valid instruction
//   br_flush           : taken branch in EXE, kill IF and ID
//   pc_we, ifid_we     : PC and IF/ID write enables
//   ifid_flush         : clear IF/ID valid
//   idexe_bubble       : load a NOP into ID/EXE
//   stalling           : controller is in the STALL state
//   perf_stall_cycles, perf_flush_cnt : optional counters, present when
//                        STALL_CTRL_PERF_EN is defined
module stall_ctrl #(
    parameter int CNT_W = pipeline_pkg::CNT_W
`ifdef STALL_CTRL_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [CNT_W-1:0] is_stall,
    input  logic             id_valid,
    input  logic             br_flush,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idexe_bubble,
    output logic             stalling
`ifdef STALL_CTRL_PERF_EN
    , output logic [PERF_W-1:0] perf_stall_cycles
    , output logic [PERF_W-1:0] perf_flush_cnt
`endif
);
    import pipeline_pkg::*;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             flush, req, busy, hold;

    // While resetn is low the outputs behave as IDLE with no request or flush.
    always_comb begin
        flush        = resetn & br_flush;
        req          = resetn & (state == STALL_IDLE) & id_valid & (is_stall != CNT_W'(STALL_NONE)) & ~br_flush;
        busy         = resetn & (state == STALL_BUSY) & (cnt != '0) & ~br_flush;
        hold         = req | busy;
        pc_we        = ~hold;
        ifid_we      = ~hold;
        ifid_flush   = flush;
        idexe_bubble = hold | flush;
        stalling     = resetn & (state == STALL_BUSY);
        state_n      = STALL_IDLE;
        cnt_n        = '0;
        // The first bubble is issued from IDLE, so cnt holds the bubbles still owed.
        if (req) begin
            cnt_n   = is_stall - CNT_W'(1);
            state_n = (is_stall > CNT_W'(STALL_MEM)) ? STALL_BUSY : STALL_IDLE;
        end else if (busy) begin
            cnt_n   = cnt - CNT_W'(1);
            state_n = (cnt == CNT_W'(1)) ? STALL_IDLE : STALL_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= STALL_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

`ifdef STALL_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_stall_cycles <= '0;
            perf_flush_cnt    <= '0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + PERF_W'(hold);
            perf_flush_cnt    <= perf_flush_cnt + PERF_W'(br_flush);
        end
    end
`endif
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed and randomized bench for stall_ctrl against a bubble-budget model.
module tb_stall_ctrl;
    logic       clk = 0;
    logic       resetn = 0;
    logic [1:0] is_stall = 0;
    logic       id_valid = 0;
    logic       br_flush = 0;
    logic       pc_we, ifid_we, ifid_flush, idexe_bubble, stalling;
`ifdef STALL_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_cnt;
`endif

    stall_ctrl dut (
        .clk(clk), .resetn(resetn), .is_stall(is_stall), .id_valid(id_valid),
        .br_flush(br_flush), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idexe_bubble(idexe_bubble), .stalling(stalling)
`ifdef STALL_CTRL_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int rem = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // rem = bubbles still owed by an accepted hazard; a new request is accepted only when none are owed.
    task automatic step(input logic rn, input logic iv, input logic [1:0] st, input logic bf);
        logic bub, fl, stl;
        int nrem;
        @(negedge clk);
        resetn = rn; id_valid = iv; is_stall = st; br_flush = bf;
        #1;
        stl  = rn && rem > 0;
        fl   = rn && bf;
        bub  = 0;
        nrem = 0;
        if (rn && !bf) begin
            if (rem > 0) begin
                bub = 1; nrem = rem - 1;
            end else if (iv && st != 0) begin
                bub = 1; nrem = int'(st) - 1;
            end
        end
        check("pc_we", 32'(pc_we), 32'(!bub));
        check("ifid_we", 32'(ifid_we), 32'(!bub));
        check("ifid_flush", 32'(ifid_flush), 32'(fl));
        check("idexe_bubble", 32'(idexe_bubble), 32'(bub | fl));
        check("stalling", 32'(stalling), 32'(stl));
`ifdef STALL_CTRL_PERF_EN
        check("perf_stall", perf_stall_cycles, 32'(m_stall));
        check("perf_flush", perf_flush_cnt, 32'(m_flush));
`endif
        @(posedge clk);
        rem = nrem;
        if (!rn) begin
            m_stall = 0; m_flush = 0;
        end else begin
            m_stall += int'(bub);
            m_flush += int'(bf);
        end
    endtask

    initial begin
        // reset held with a pending request
        step(0, 1, 2, 0); step(0, 1, 2, 0); step(1, 1, 0, 0);
        // EXE hazard: is_stall stays 2 while stalling
        step(1, 1, 2, 0); step(1, 1, 2, 0); step(1, 1, 2, 0); step(1, 1, 0, 0);
        // MEM hazard
        step(1, 1, 1, 0); step(1, 1, 0, 0);
        // flush preempts an in-progress stall
        step(1, 1, 2, 0); step(1, 1, 2, 1); step(1, 1, 0, 0); step(1, 1, 0, 0);
        // invalid ID, then flush with simultaneous request
        step(1, 0, 2, 0); step(1, 1, 1, 1); step(1, 1, 0, 0);
        // unused encoding 3 gives 3 bubbles
        step(1, 1, 3, 0); step(1, 1, 3, 0); step(1, 1, 3, 0); step(1, 1, 0, 0);
        // reset mid-stall
        step(1, 1, 2, 0); step(0, 1, 2, 0); step(1, 1, 0, 0);
        // three hazards (2,1,2) and one flush from a fresh reset
        step(0, 0, 0, 0);
        step(1, 1, 2, 0); step(1, 1, 0, 0); step(1, 1, 1, 0); step(1, 1, 2, 0);
        step(1, 1, 0, 0); step(1, 1, 0, 1); step(1, 1, 0, 0);
`ifdef STALL_CTRL_PERF_EN
        @(negedge clk);
        check("perf_stall_total", perf_stall_cycles, 32'd5);
        check("perf_flush_total", perf_flush_cnt, 32'd1);
`endif
        for (int i = 0; i < 600; i++)
            step(logic'($urandom_range(0, 39) != 0), logic'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), logic'($urandom_range(0, 7) == 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
